// File: rtl/turbo_out_packer_pkg.sv
// Shared definitions for the turbo encoder output packer: packer state
// encodings and the symbol/byte geometry of the coded stream.
package turbo_out_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2
    } pack_state_t;

    localparam int SYM_W          = 6;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_4SYM = 3;

    // Accumulator holds at most 6 leftover bits plus one new symbol.
    localparam int ACC_W = 14;
    localparam int CNT_W = 4;

endpackage

// File: rtl/turbo_byte_fifo.sv
// First-word-fall-through FIFO with a registered output word. The head entry
// is moved into the output register one edge after it is written; count
// covers every stored entry including the one being presented.
module turbo_byte_fifo #(
    parameter int DATA_W = 9,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [DATA_W-1:0] mem [1 << AW];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [AW:0]       mem_cnt;
    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic              push;
    logic              pop;
    logic              load;

    // A pop frees the output register in the same cycle, so a write into a
    // full FIFO still lands when the head is taken at the same edge.
    always_comb begin
        pop     = out_vld & rd_en;
        full    = (cnt == DEPTH);
        push    = wr_en & (~full | pop);
        mem_cnt = cnt - {{AW{1'b0}}, out_vld};
        load    = (mem_cnt != '0) & (~out_vld | pop);
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_data <= mem[rd_ptr];
                out_vld  <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign rd_data = out_data;
    assign count   = cnt;
    assign empty   = ~out_vld;

endmodule

// File: rtl/turbo_out_packer.sv
// Packs the encoder's 6-bit coded symbols MSB-first into bytes, buffers them
// in a byte FIFO and drains them over a valid/ready interface. The encoder is
// only granted a frame when the FIFO can absorb all 3*blocksize bytes.
module turbo_out_packer
    import turbo_out_packer_pkg::*;
#(
    parameter int MAX_BLOCK_WIDTH = 10,
    parameter int FIFO_AW         = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [MAX_BLOCK_WIDTH-1:0] i_conf_blocksize,
    input  logic                       i_valid,
    input  logic                       i_bof,
    input  logic                       i_eof,
    input  logic [SYM_W-1:0]           i_data,
    output logic                       o_enc_ready,
    output logic [BYTE_W-1:0]          o_m_data,
    output logic                       o_m_valid,
    input  logic                       i_m_ready,
    output logic                       o_m_last,
    output logic                       o_busy,
    output logic                       o_overflow,
    output logic                       o_frame_err
);

    localparam int          FW    = FIFO_AW + 1;
    localparam logic [FW-1:0] DEPTH = FW'(1 << FIFO_AW);

    pack_state_t state;
    pack_state_t state_next;

    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        bcnt;
    logic [BYTE_W-1:0]       base_acc;
    logic [CNT_W-1:0]        base_cnt;
    logic [ACC_W-1:0]        app_acc;
    logic [CNT_W-1:0]        app_cnt;
    logic [CNT_W-1:0]        rem;
    logic                    emit;
    logic [BYTE_W-1:0]       emit_byte;
    logic [ACC_W+BYTE_W-1:0] flush_wide;
    logic [BYTE_W-1:0]       flush_byte;

    logic                    accept;
    logic                    flush;
    logic                    err_set;
    logic                    wr_en;
    logic [BYTE_W:0]         wr_word;
    logic                    pop;

    logic [BYTE_W:0]         rd_word;
    logic [FW-1:0]           fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    logic [FW-1:0]           free_entries;
    logic [FW-1:0]           need;
    logic                    ready_ok;

    logic                    enc_ready;
    logic                    overflow;
    logic                    frame_err;

    // Append the incoming symbol below the leftover bits and extract the top
    // byte once at least 8 bits are held. A new frame starts from empty.
    always_comb begin
        base_acc   = (state == ST_IDLE) ? '0 : acc[BYTE_W-1:0];
        base_cnt   = (state == ST_IDLE) ? '0 : bcnt;
        app_acc    = {base_acc, i_data};
        app_cnt    = base_cnt + CNT_W'(SYM_W);
        emit       = (app_cnt >= CNT_W'(BYTE_W));
        emit_byte  = BYTE_W'(app_acc >> (app_cnt - CNT_W'(BYTE_W)));
        rem        = emit ? (app_cnt - CNT_W'(BYTE_W)) : app_cnt;
        // Remainder bits left-aligned with zero padding below them.
        flush_wide = {acc, {BYTE_W{1'b0}}} >> bcnt;
        flush_byte = flush_wide[BYTE_W-1:0];
    end

    // Packer next-state and per-cycle control.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        flush      = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (i_bof) begin
                        accept     = 1'b1;
                        state_next = ST_COLLECT;
                        if (i_eof) begin
                            state_next = (rem != '0) ? ST_FLUSH : ST_IDLE;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (i_valid) begin
                    accept = 1'b1;
                    if (i_bof) begin
                        err_set = 1'b1;
                    end
                    if (i_eof) begin
                        state_next = (rem != '0) ? ST_FLUSH : ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                flush      = 1'b1;
                state_next = ST_IDLE;
                if (i_valid) begin
                    err_set = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO write word, pop request and frame-level ready decision. The byte
    // being written this cycle is charged against free space so a grant is
    // never issued one entry short.
    always_comb begin
        wr_en        = (accept & emit) | flush;
        wr_word      = flush ? {1'b1, flush_byte}
                             : {i_eof & (rem == '0), emit_byte};
        pop          = ~fifo_empty & i_m_ready;
        free_entries = DEPTH - fifo_count;
        need         = FW'(BYTES_PER_4SYM) * FW'(i_conf_blocksize);
        ready_ok     = (state_next == ST_IDLE) &&
                       ({1'b0, free_entries} >= ({1'b0, need} + (FW+1)'(wr_en)));
    end

    // State register, accumulator, ready register and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            bcnt      <= '0;
            enc_ready <= 1'b1;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc  <= app_acc;
                bcnt <= rem;
            end else if (flush) begin
                bcnt <= '0;
            end
            enc_ready <= ready_ok;
            if (err_set) begin
                frame_err <= 1'b1;
            end
            if (wr_en & fifo_full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

    turbo_byte_fifo #(
        .DATA_W (BYTE_W + 1),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (rd_word),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_enc_ready = enc_ready;
    assign o_m_valid   = ~fifo_empty;
    assign o_m_data    = rd_word[BYTE_W-1:0];
    assign o_m_last    = rd_word[BYTE_W];
    assign o_busy      = (state != ST_IDLE);
    assign o_overflow  = overflow;
    assign o_frame_err = frame_err;

endmodule

// File: tb/tb_turbo_out_packer.sv
// Bench for turbo_out_packer: a frame-level bit-queue model predicts the byte
// stream, a negedge process compares every popped byte and checks hold
// stability, and directed tests pin the literal values and flag behaviour.
module tb_turbo_out_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] blocksize = 10'd1;
    logic       valid = 1'b0;
    logic       bof = 1'b0;
    logic       eof = 1'b0;
    logic [5:0] data = 6'd0;
    logic       m_ready = 1'b1;
    logic       m_ready_s = 1'b1;

    logic       enc_ready, m_valid, m_last, busy, overflow, frame_err;
    logic [7:0] m_data;
    logic       enc_ready_s, m_valid_s, m_last_s, busy_s, overflow_s, frame_err_s;
    logic [7:0] m_data_s;

    int total = 0;
    int bad   = 0;
    int pop_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       mid_ready;
    logic       hold_vld = 1'b0;
    logic [8:0] hold_val;

    always #5 clk = ~clk;

    turbo_out_packer #(.MAX_BLOCK_WIDTH(10), .FIFO_AW(12)) dut (
        .i_clk(clk), .i_rst(rst), .i_conf_blocksize(blocksize),
        .i_valid(valid), .i_bof(bof), .i_eof(eof), .i_data(data),
        .o_enc_ready(enc_ready), .o_m_data(m_data), .o_m_valid(m_valid),
        .i_m_ready(m_ready), .o_m_last(m_last), .o_busy(busy),
        .o_overflow(overflow), .o_frame_err(frame_err)
    );

    turbo_out_packer #(.MAX_BLOCK_WIDTH(10), .FIFO_AW(2)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_conf_blocksize(blocksize),
        .i_valid(valid), .i_bof(bof), .i_eof(eof), .i_data(data),
        .o_enc_ready(enc_ready_s), .o_m_data(m_data_s), .o_m_valid(m_valid_s),
        .i_m_ready(m_ready_s), .o_m_last(m_last_s), .o_busy(busy_s),
        .o_overflow(overflow_s), .o_frame_err(frame_err_s)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    // Frame model: concatenate the symbols as a bit string, cut it into
    // bytes MSB-first, zero-pad the tail and mark the final byte as last.
    task automatic pack_frame(input logic [5:0] syms[$], output logic [8:0] res[$]);
        bit         bq[$];
        logic [7:0] b;
        res = {};
        foreach (syms[i]) for (int k = 5; k >= 0; k--) bq.push_back(syms[i][k]);
        while (bq.size() > 0) begin
            b = 8'h00;
            for (int k = 7; k >= 0; k--) if (bq.size() > 0) b[k] = bq.pop_front();
            res.push_back({1'b0, b});
        end
        if (res.size() > 0) res[res.size()-1][8] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sym(input logic [5:0] d, input logic b, input logic e);
        valid = 1'b1; data = d; bof = b; eof = e;
        tick();
        valid = 1'b0; data = 6'd0; bof = 1'b0; eof = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] syms[$]);
        logic [8:0] res[$];
        pack_frame(syms, res);
        foreach (res[i]) exp_q.push_back(res[i]);
        foreach (syms[i]) begin
            drive_sym(syms[i], i == 0, i == syms.size() - 1);
            if (i == 1) mid_ready = enc_ready;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; bof = 1'b0; eof = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Every byte the big instance hands over is compared with the model; a
    // stalled byte must not change until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && m_valid)
                check("hold_stable", {m_last, m_data}, hold_val);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_pop", {m_last, m_data}, 32'hFFFF_FFFF);
                else check("pop_byte", {m_last, m_data}, exp_q.pop_front());
                got_q.push_back({m_last, m_data});
                pop_cnt++;
            end
            hold_vld = m_valid && !m_ready;
            hold_val = {m_last, m_data};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] s[$];
        logic [8:0] r[$];
        logic [7:0] lit[4];
        int         pc0;

        // Reset values
        tick(); tick();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_enc_ready", enc_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Model pinned against a hand-computed single-symbol frame
        s = '{6'h2D};
        pack_frame(s, r);
        check("model_single", r[0], 9'h1B4);

        // Four-symbol frame, no flush
        blocksize = 10'd1; m_ready = 1'b1; got_q.delete();
        s = '{6'h3F, 6'h00, 6'h2A, 6'h15};
        send_frame(s);
        repeat (5) tick();
        check("t1_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t1_b0", got_q[0], 9'h0FC);
            check("t1_b1", got_q[1], 9'h00A);
            check("t1_b2", got_q[2], 9'h195);
        end
        check("t1_frame_err", frame_err, 1'b0);
        check("t1_busy", busy, 1'b0);

        // Single-symbol frame goes through FLUSH
        got_q.delete();
        drive_sym(6'h2D, 1'b1, 1'b1);
        exp_q.push_back(9'h1B4);
        check("t2_busy_flush", busy, 1'b1);
        repeat (5) tick();
        check("t2_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t2_byte", got_q[0], 9'h1B4);
        check("t2_busy_after", busy, 1'b0);

        // Stalled downstream, blocksize 2
        blocksize = 10'd2; m_ready = 1'b0;
        s = '{6'h3F, 6'h00, 6'h2A, 6'h15, 6'h01, 6'h23, 6'h3C, 6'h0F};
        send_frame(s);
        repeat (6) tick();
        check("t3_valid_held", m_valid, 1'b1);
        check("t3_data_head", m_data, 8'hFC);
        pc0 = pop_cnt;
        m_ready = 1'b1;
        repeat (6) tick();
        m_ready = 1'b0;
        check("t3_pops", pop_cnt - pc0, 6);
        check("t3_empty_after", m_valid, 1'b0);

        // Frame-level ready with a deep frame
        blocksize = 10'd1000; m_ready = 1'b0;
        repeat (2) tick();
        check("t4_ready_init", enc_ready, 1'b1);
        s.delete();
        for (int i = 0; i < 4000; i++) s.push_back(6'((i * 7 + 3) & 63));
        send_frame(s);
        check("t4_ready_mid", mid_ready, 1'b0);
        repeat (4) tick();
        check("t4_ready_full", enc_ready, 1'b0);
        check("t4_busy", busy, 1'b0);
        pc0 = pop_cnt;
        m_ready = 1'b1;
        repeat (1903) tick();
        m_ready = 1'b0;
        repeat (3) tick();
        check("t4_pops_1903", pop_cnt - pc0, 1903);
        check("t4_ready_1903", enc_ready, 1'b0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (3) tick();
        check("t4_ready_1904", enc_ready, 1'b1);
        m_ready = 1'b1;
        for (int c = 0; c < 1500 && exp_q.size() != 0; c++) tick();
        check("t4_drained", exp_q.size(), 0);

        // Overflow on the small FIFO
        do_reset();
        blocksize = 10'd2; m_ready = 1'b0; m_ready_s = 1'b0;
        s = '{6'h3F, 6'h00, 6'h2A, 6'h15, 6'h3F, 6'h00, 6'h2A, 6'h15};
        send_frame(s);
        repeat (4) tick();
        check("t5_overflow", overflow_s, 1'b1);
        check("t5_big_no_overflow", overflow, 1'b0);
        repeat (3) tick();
        check("t5_overflow_sticky", overflow_s, 1'b1);
        lit[0] = 8'hFC; lit[1] = 8'h0A; lit[2] = 8'h95; lit[3] = 8'hFC;
        m_ready_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t5_kept_valid", m_valid_s, 1'b1);
            check("t5_kept_byte", m_data_s, lit[k]);
            tick();
        end
        check("t5_small_empty", m_valid_s, 1'b0);
        check("t5_overflow_still", overflow_s, 1'b1);
        m_ready = 1'b1;
        repeat (10) tick();
        check("t5_big_drained", exp_q.size(), 0);
        do_reset();
        check("t5_overflow_cleared", overflow_s, 1'b0);

        // Symbol without bof while idle
        drive_sym(6'h11, 1'b0, 1'b0);
        repeat (3) tick();
        check("t6_frame_err", frame_err, 1'b1);
        check("t6_no_write", m_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        do_reset();
        check("t6_err_cleared", frame_err, 1'b0);

        // Reset in the middle of a frame
        blocksize = 10'd1; m_ready = 1'b0;
        drive_sym(6'h3F, 1'b1, 1'b0);
        drive_sym(6'h00, 1'b0, 1'b0);
        drive_sym(6'h2A, 1'b0, 1'b0);
        repeat (2) tick();
        check("t7_pre_valid", m_valid, 1'b1);
        check("t7_pre_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("t7_valid", m_valid, 1'b0);
        check("t7_enc_ready", enc_ready, 1'b1);
        check("t7_busy", busy, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        m_ready = 1'b1;
        s = '{6'h15, 6'h2A, 6'h00, 6'h3F};
        send_frame(s);
        repeat (6) tick();
        check("t7_after_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
